// File: rtl/axi_lite_master_if.sv
// Bundles the user command/response handshake and the AXI-Lite master bus of
// axi_lite_master; the master modport is the block side, slave the far side.
interface axi_lite_master_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_write;
  logic [ADDR_WIDTH-1:0]     cmd_addr;
  logic [DATA_WIDTH-1:0]     cmd_wdata;
  logic [DATA_WIDTH/8-1:0]   cmd_wstrb;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic                      rsp_write;
  logic [DATA_WIDTH-1:0]     rsp_rdata;
  logic [1:0]                rsp_resp;

  logic [ADDR_WIDTH-1:0]     AWADDR;
  logic                      AWVALID;
  logic                      AWREADY;
  logic [DATA_WIDTH-1:0]     WDATA;
  logic [DATA_WIDTH/8-1:0]   WSTRB;
  logic                      WVALID;
  logic                      WREADY;
  logic [1:0]                BRESP;
  logic                      BVALID;
  logic                      BREADY;
  logic [ADDR_WIDTH-1:0]     ARADDR;
  logic                      ARVALID;
  logic                      ARREADY;
  logic [DATA_WIDTH-1:0]     RDATA;
  logic [1:0]                RRESP;
  logic                      RVALID;
  logic                      RREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    output cmd_ready,
    output rsp_valid, rsp_write, rsp_rdata, rsp_resp,
    input  rsp_ready,
    output AWADDR, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WVALID,
    input  WREADY,
    input  BRESP, BVALID,
    output BREADY,
    output ARADDR, ARVALID,
    input  ARREADY,
    input  RDATA, RRESP, RVALID,
    output RREADY
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    input  cmd_ready,
    input  rsp_valid, rsp_write, rsp_rdata, rsp_resp,
    output rsp_ready,
    input  AWADDR, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WVALID,
    output WREADY,
    output BRESP, BVALID,
    input  BREADY,
    input  ARADDR, ARVALID,
    output ARREADY,
    output RDATA, RRESP, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/axi_lite_master.sv
// AXI-Lite master: issues one user command at a time as an AXI-Lite read or
// write and presents the captured response on the rsp_* handshake.
module axi_lite_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  axi_lite_master_if.master bus
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    arvalid_q, arvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              resp_q, resp_d;
  logic                    rsp_write_q, rsp_write_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rdata_q     <= '0;
      resp_q      <= '0;
      rsp_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      rsp_write_q <= rsp_write_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    rsp_write_d = rsp_write_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_write) begin
            awaddr_d  = bus.cmd_addr;
            wdata_d   = bus.cmd_wdata;
            wstrb_d   = bus.cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            araddr_d  = bus.cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        // AW and W retire independently; leave once neither is still pending,
        // which also covers both handshakes landing on the same edge.
        if (awvalid_q && bus.AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && bus.WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)  state_d   = WR_RESP;
      end
      WR_RESP: begin
        if (bus.BVALID) begin
          resp_d      = bus.BRESP;
          rdata_d     = '0;
          rsp_write_d = 1'b1;
          state_d     = RSP;
        end
      end
      RD_REQ: begin
        if (bus.ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (bus.RVALID) begin
          rdata_d     = bus.RDATA;
          resp_d      = bus.RRESP;
          rsp_write_d = 1'b0;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.BREADY    = (state_q == WR_RESP);
  assign bus.RREADY    = (state_q == RD_DATA);
  assign bus.rsp_valid = (state_q == RSP);
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_resp  = resp_q;
  assign bus.AWADDR    = awaddr_q;
  assign bus.AWVALID   = awvalid_q;
  assign bus.WDATA     = wdata_q;
  assign bus.WSTRB     = wstrb_q;
  assign bus.WVALID    = wvalid_q;
  assign bus.ARADDR    = araddr_q;
  assign bus.ARVALID   = arvalid_q;
endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a memory slave with programmable handshake delays
// plus a byte-masked reference memory and latency formula as the model.
module tb_axi_lite_master;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [DW-1:0] smem    [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  axi_lite_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  axi_lite_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  function automatic void ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                    input logic [SW-1:0] s);
    logic [DW-1:0] mask;
    mask = '0;
    for (int unsigned b = 0; b < SW; b++) if (s[b]) mask[b*8 +: 8] = 8'hFF;
    ref_mem[a] = (ref_read(a) & ~mask) | (d & mask);
  endfunction

  // Drives one command plus the slave side cycle by cycle at negedges;
  // protocol breaches are tallied into o_viol for the caller to judge.
  task automatic run_txn(
    input  logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
    input  logic [SW-1:0] strb,
    input  int aw_lat, input int w_lat, input int ar_lat, input int b_lat,
    input  int r_lat, input int rsp_lat, input logic [1:0] resp,
    output logic [DW-1:0] o_rdata, output logic [1:0] o_resp, output logic o_write,
    output int o_rsp_cyc, output int o_viol, output logic o_timeout,
    output logic [AW-1:0] o_addr, output logic [DW-1:0] o_wdata,
    output int o_a_cyc, output int o_w_cyc);
    logic acc, aw_d, w_d, b_d, ar_d, r_d, aw_s, w_s, ar_s, rs_s, mem_done, done;
    int acc_c, aw_c, w_c, both_c, b_c, ar_c, r_c, aw_n, w_n, ar_n, rsp_n;
    logic [AW-1:0] aw_h, ar_h;
    logic [DW-1:0] wd_h, rd_p, cur;
    logic [SW-1:0] ws_h;
    logic [1:0] rr_p;
    logic rw_p;
    logic [63:0] rnd;
    acc = 0; aw_d = 0; w_d = 0; b_d = 0; ar_d = 0; r_d = 0;
    aw_s = 0; w_s = 0; ar_s = 0; rs_s = 0; mem_done = 0; done = 0;
    acc_c = 0; aw_c = 0; w_c = 0; both_c = 0; b_c = 0; ar_c = 0; r_c = 0;
    aw_n = 0; w_n = 0; ar_n = 0; rsp_n = 0;
    aw_h = '0; ar_h = '0; wd_h = '0; ws_h = '0; rd_p = '0; rr_p = '0; rw_p = 0; cur = '0;
    o_rdata = '0; o_resp = '0; o_write = 0; o_rsp_cyc = -1; o_viol = 0; o_timeout = 0;
    o_addr = '0; o_wdata = '0; o_a_cyc = -1; o_w_cyc = -1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      rnd = {$urandom(), $urandom()};
      if (!acc) begin
        bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr;
        bus.cmd_wdata = data; bus.cmd_wstrb = strb;
        if (bus.cmd_ready) begin acc = 1; acc_c = c; end
      end else begin
        bus.cmd_valid = 1'($urandom); bus.cmd_write = 1'($urandom);
        bus.cmd_addr = AW'($urandom); bus.cmd_wdata = rnd[DW-1:0]; bus.cmd_wstrb = SW'($urandom);
        if (bus.cmd_ready) o_viol++;
      end
      // write address / data channels
      bus.AWREADY = 1'b0;
      if (bus.AWVALID) begin
        if (!wr || aw_d) o_viol++;
        if (aw_s && bus.AWADDR !== aw_h) o_viol++;
        aw_s = 1; aw_h = bus.AWADDR;
        if (aw_n >= aw_lat) begin bus.AWREADY = 1'b1; aw_d = 1; aw_c = c; end
        aw_n++;
      end else if (aw_s && !aw_d) o_viol++;
      bus.WREADY = 1'b0;
      if (bus.WVALID) begin
        if (!wr || w_d) o_viol++;
        if (w_s && (bus.WDATA !== wd_h || bus.WSTRB !== ws_h)) o_viol++;
        w_s = 1; wd_h = bus.WDATA; ws_h = bus.WSTRB;
        if (w_n >= w_lat) begin bus.WREADY = 1'b1; w_d = 1; w_c = c; end
        w_n++;
      end else if (w_s && !w_d) o_viol++;
      if (aw_d && w_d && !mem_done) begin
        cur = smem.exists(aw_h) ? smem[aw_h] : '0;
        for (int unsigned b = 0; b < SW; b++) if (ws_h[b]) cur[b*8 +: 8] = wd_h[b*8 +: 8];
        smem[aw_h] = cur; mem_done = 1;
        both_c = (aw_c > w_c) ? aw_c : w_c;
      end
      // write response channel
      bus.BVALID = 1'b0; bus.BRESP = 2'($urandom);
      if (bus.BREADY && (b_d || !(mem_done && c > both_c))) o_viol++;
      if (wr && mem_done && !b_d && c > both_c + b_lat) begin
        bus.BVALID = 1'b1; bus.BRESP = resp;
        if (bus.BREADY) begin b_d = 1; b_c = c; end
      end
      // read address / data channels
      bus.ARREADY = 1'b0;
      if (bus.ARVALID) begin
        if (wr || ar_d) o_viol++;
        if (ar_s && bus.ARADDR !== ar_h) o_viol++;
        ar_s = 1; ar_h = bus.ARADDR;
        if (ar_n >= ar_lat) begin bus.ARREADY = 1'b1; ar_d = 1; ar_c = c; end
        ar_n++;
      end else if (ar_s && !ar_d) o_viol++;
      bus.RVALID = 1'b0; bus.RRESP = 2'($urandom); bus.RDATA = rnd[DW-1:0];
      if (bus.RREADY && (r_d || !(ar_d && c > ar_c))) o_viol++;
      if (!wr && ar_d && !r_d && c > ar_c + r_lat) begin
        bus.RVALID = 1'b1; bus.RRESP = resp;
        bus.RDATA = smem.exists(ar_h) ? smem[ar_h] : '0;
        if (bus.RREADY) begin r_d = 1; r_c = c; end
      end
      // user response
      bus.rsp_ready = 1'b0;
      if (bus.rsp_valid) begin
        if (!(wr ? (b_d && c > b_c) : (r_d && c > r_c))) o_viol++;
        if (rs_s && {bus.rsp_rdata, bus.rsp_resp, bus.rsp_write} !== {rd_p, rr_p, rw_p}) o_viol++;
        if (!rs_s) o_rsp_cyc = c - acc_c;
        rs_s = 1; rd_p = bus.rsp_rdata; rr_p = bus.rsp_resp; rw_p = bus.rsp_write;
        if (rsp_n >= rsp_lat) begin
          bus.rsp_ready = 1'b1; done = 1;
          o_rdata = bus.rsp_rdata; o_resp = bus.rsp_resp; o_write = bus.rsp_write;
        end
        rsp_n++;
      end
    end
    if (!done) o_timeout = 1;
    o_addr  = wr ? aw_h : ar_h;
    o_wdata = wd_h;
    o_a_cyc = (wr ? aw_c : ar_c) - acc_c;
    o_w_cyc = w_c - acc_c;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.AWREADY = 1'b0; bus.WREADY = 1'b0; bus.BVALID = 1'b0;
    bus.ARREADY = 1'b0; bus.RVALID = 1'b0; bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.AWVALID, bus.WVALID, bus.ARVALID, bus.BREADY, bus.RREADY, bus.rsp_valid} !== 6'b0) begin
      bad++;
      $display("FAIL reset_valids got=%b exp=000000", {bus.AWVALID, bus.WVALID, bus.ARVALID,
               bus.BREADY, bus.RREADY, bus.rsp_valid});
    end
    total++;
    if ({bus.AWADDR, bus.WDATA, bus.WSTRB, bus.ARADDR} !== '0) begin
      bad++;
      $display("FAIL reset_bus_regs got=%h/%h/%h/%h exp=0", bus.AWADDR, bus.WDATA, bus.WSTRB, bus.ARADDR);
    end
    total++;
    if ({bus.rsp_rdata, bus.rsp_resp, bus.rsp_write} !== '0) begin
      bad++;
      $display("FAIL reset_rsp_regs got=%h/%h/%b exp=0", bus.rsp_rdata, bus.rsp_resp, bus.rsp_write);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.cmd_ready !== 1'b1) begin
      bad++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready);
    end
  endtask

  task automatic test_write_basic();
    logic [DW-1:0] rd, wd; logic [1:0] rr; logic rw, to; logic [AW-1:0] aa; int rc, vi, ac, wc;
    run_txn(1'b1, AW'(32'h10), DW'(32'hDEADBEEF), '1, 0, 0, 0, 0, 0, 0, 2'b00,
            rd, rr, rw, rc, vi, to, aa, wd, ac, wc);
    ref_write(AW'(32'h10), DW'(32'hDEADBEEF), '1);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL wr_basic_timeout got=%b exp=0", to); end
    total++; if (vi !== 0) begin bad++; $display("FAIL wr_basic_protocol got=%0d exp=0", vi); end
    total++; if (ac !== 1 || wc !== 1) begin bad++; $display("FAIL wr_basic_hs_cycle got=%0d/%0d exp=1/1", ac, wc); end
    total++; if (aa !== AW'(32'h10)) begin bad++; $display("FAIL wr_basic_awaddr got=%h exp=10", aa); end
    total++; if (wd !== DW'(32'hDEADBEEF)) begin bad++; $display("FAIL wr_basic_wdata got=%h exp=deadbeef", wd); end
    total++; if (rc !== 3) begin bad++; $display("FAIL wr_basic_latency got=%0d exp=3", rc); end
    total++;
    if ({rw, rr, rd} !== {1'b1, 2'b00, DW'(0)}) begin
      bad++; $display("FAIL wr_basic_rsp got=%b/%h/%h exp=1/0/0", rw, rr, rd);
    end
  endtask

  task automatic test_read_back();
    logic [DW-1:0] rd, wd; logic [1:0] rr; logic rw, to; logic [AW-1:0] aa; int rc, vi, ac, wc;
    run_txn(1'b0, AW'(32'h10), '0, '0, 0, 0, 0, 0, 0, 0, 2'b00,
            rd, rr, rw, rc, vi, to, aa, wd, ac, wc);
    total++; if (to !== 1'b0 || vi !== 0) begin bad++; $display("FAIL rd_back_protocol got=%b/%0d exp=0/0", to, vi); end
    total++; if (aa !== AW'(32'h10) || ac !== 1) begin bad++; $display("FAIL rd_back_araddr got=%h@%0d exp=10@1", aa, ac); end
    total++; if (rd !== ref_read(AW'(32'h10))) begin bad++; $display("FAIL rd_back_rdata got=%h exp=%h", rd, ref_read(AW'(32'h10))); end
    total++; if (rr !== 2'b00 || rw !== 1'b0) begin bad++; $display("FAIL rd_back_resp got=%h/%b exp=0/0", rr, rw); end
    total++; if (rc !== 3) begin bad++; $display("FAIL rd_back_latency got=%0d exp=3", rc); end
  endtask

  task automatic test_wready_stall();
    logic [DW-1:0] rd, wd, d; logic [1:0] rr; logic rw, to; logic [AW-1:0] aa; int rc, vi, ac, wc;
    d = DW'($urandom);
    run_txn(1'b1, AW'(32'h20), d, SW'(4'h5), 0, 5, 0, 0, 0, 0, 2'b00,
            rd, rr, rw, rc, vi, to, aa, wd, ac, wc);
    ref_write(AW'(32'h20), d, SW'(4'h5));
    total++; if (to !== 1'b0 || vi !== 0) begin bad++; $display("FAIL wstall_protocol got=%b/%0d exp=0/0", to, vi); end
    total++; if (ac !== 1) begin bad++; $display("FAIL wstall_aw_cycle got=%0d exp=1", ac); end
    total++; if (wc !== 6) begin bad++; $display("FAIL wstall_w_cycle got=%0d exp=6", wc); end
    total++; if (wd !== d) begin bad++; $display("FAIL wstall_wdata got=%h exp=%h", wd, d); end
    total++; if (rc !== 8 || rw !== 1'b1) begin bad++; $display("FAIL wstall_rsp got=%0d/%b exp=8/1", rc, rw); end
  endtask

  task automatic test_rresp_hold();
    logic [DW-1:0] rd, wd; logic [1:0] rr; logic rw, to; logic [AW-1:0] aa; int rc, vi, ac, wc;
    run_txn(1'b0, AW'(32'h20), '0, '0, 0, 0, 0, 0, 0, 4, 2'b10,
            rd, rr, rw, rc, vi, to, aa, wd, ac, wc);
    total++; if (to !== 1'b0 || vi !== 0) begin bad++; $display("FAIL rresp_protocol got=%b/%0d exp=0/0", to, vi); end
    total++; if (rr !== 2'b10) begin bad++; $display("FAIL rresp_value got=%b exp=10", rr); end
    total++; if (rd !== ref_read(AW'(32'h20))) begin bad++; $display("FAIL rresp_rdata got=%h exp=%h", rd, ref_read(AW'(32'h20))); end
    total++; if (rc !== 3) begin bad++; $display("FAIL rresp_latency got=%0d exp=3", rc); end
    @(negedge clk);
    total++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL rresp_idle got=%b/%b exp=1/0", bus.cmd_ready, bus.rsp_valid);
    end
  endtask

  task automatic test_spurious_bvalid();
    logic [DW-1:0] rd, wd, d; logic [1:0] rr; logic rw, to; logic [AW-1:0] aa; int rc, vi, ac, wc;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({bus.BREADY, bus.RREADY, bus.rsp_valid, bus.cmd_ready} !== 4'b0001) begin
        bad++; $display("FAIL spurious_idle[%0d] got=%b exp=0001", i,
                        {bus.BREADY, bus.RREADY, bus.rsp_valid, bus.cmd_ready});
      end
      bus.BVALID = (i < 3); bus.BRESP = 2'b11;
      bus.RVALID = (i < 3); bus.RRESP = 2'b11;
    end
    d = DW'($urandom);
    run_txn(1'b1, AW'(32'h30), d, '1, 0, 0, 0, 0, 0, 0, 2'b00,
            rd, rr, rw, rc, vi, to, aa, wd, ac, wc);
    ref_write(AW'(32'h30), d, '1);
    total++;
    if (to !== 1'b0 || vi !== 0 || rc !== 3 || rr !== 2'b00) begin
      bad++; $display("FAIL spurious_after got=%b/%0d/%0d/%b exp=0/0/3/00", to, vi, rc, rr);
    end
  endtask

  task automatic test_reset_mid_read();
    logic ok;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = AW'(32'h40); bus.ARREADY = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    total++; if (bus.ARVALID !== 1'b1) begin bad++; $display("FAIL rstmid_arvalid_pre got=%b exp=1", bus.ARVALID); end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus.ARVALID, bus.ARADDR} !== {1'b0, AW'(0)}) begin
      bad++; $display("FAIL rstmid_async got=%b/%h exp=0/0", bus.ARVALID, bus.ARADDR);
    end
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rstmid_idle got=%b exp=1", bus.cmd_ready); end
    @(negedge clk);
    rst = 1'b0;
    bus.ARREADY = 1'b1; bus.RVALID = 1'b1; bus.RDATA = DW'($urandom);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0 || bus.ARVALID !== 1'b0 || bus.cmd_ready !== 1'b1) ok = 1'b0;
    end
    total++;
    if (ok !== 1'b1) begin
      bad++; $display("FAIL rstmid_after got=%b/%b/%b exp=0/0/1", bus.rsp_valid, bus.ARVALID, bus.cmd_ready);
    end
    bus.ARREADY = 1'b0; bus.RVALID = 1'b0;
  endtask

  task automatic test_random();
    logic [DW-1:0] rd, wd, d, er; logic [1:0] rr, rs; logic rw, to, wr; logic [AW-1:0] aa, a;
    logic [SW-1:0] s; int rc, vi, ac, wc, al, wl, arl, bl, rl, kl, el;
    for (int n = 0; n < 60; n++) begin
      wr = 1'($urandom); a = AW'($urandom_range(0, 7) << 2);
      d = DW'($urandom); s = SW'($urandom); rs = 2'($urandom);
      al = $urandom_range(0, 3); wl = $urandom_range(0, 3); arl = $urandom_range(0, 3);
      bl = $urandom_range(0, 3); rl = $urandom_range(0, 3); kl = $urandom_range(0, 2);
      el = wr ? 3 + ((al > wl) ? al : wl) + bl : 3 + arl + rl;
      er = wr ? '0 : ref_read(a);
      run_txn(wr, a, d, s, al, wl, arl, bl, rl, kl, rs, rd, rr, rw, rc, vi, to, aa, wd, ac, wc);
      if (wr) ref_write(a, d, s);
      total++; if (to !== 1'b0 || vi !== 0) begin bad++; $display("FAIL rand[%0d]_protocol got=%b/%0d exp=0/0", n, to, vi); end
      total++; if (rd !== er) begin bad++; $display("FAIL rand[%0d]_rdata wr=%b a=%h got=%h exp=%h", n, wr, a, rd, er); end
      total++; if (rr !== rs) begin bad++; $display("FAIL rand[%0d]_resp got=%b exp=%b", n, rr, rs); end
      total++; if (rw !== wr) begin bad++; $display("FAIL rand[%0d]_write got=%b exp=%b", n, rw, wr); end
      total++; if (rc !== el) begin bad++; $display("FAIL rand[%0d]_latency got=%0d exp=%0d", n, rc, el); end
      total++; if (aa !== a) begin bad++; $display("FAIL rand[%0d]_addr got=%h exp=%h", n, aa, a); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0; bus.cmd_wstrb = '0;
    bus.rsp_ready = 1'b0; bus.AWREADY = 1'b0; bus.WREADY = 1'b0; bus.BVALID = 1'b0; bus.BRESP = '0;
    bus.ARREADY = 1'b0; bus.RVALID = 1'b0; bus.RRESP = '0; bus.RDATA = '0;
    test_reset();
    test_write_basic();
    test_read_back();
    test_wready_stall();
    test_rresp_hold();
    test_spurious_bvalid();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
